uart_rx_ctrl: RTL and testbench

//  Receive-side sequencer between the oversampling UART receiver and the host.
//  - Drains each received byte via the receiver's readdata/clearerr handshake.
//  - Tags the byte with its framing status and queues it in a FIFO.
//  - Presents queued bytes to the host on a valid/ready stream.
//  - Keeps sticky overrun/overflow status for firmware polling.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_fifo.sv | 78 +++++++
 rtl/uart_rx_ctrl.sv | 158 +++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-side sequencer and its FIFO.
// Each FIFO entry is {framing_error, data}, so the error flag sits at bit ERR_BIT.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK   = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DRAIN = 2'd3
    } rx_state_e;

    localparam int DATA_W  = 8;
    localparam int ENTRY_W = DATA_W + 1;
    localparam int ERR_BIT = DATA_W;

endpackage

// File: rtl/uart_rx_fifo.sv
// DEPTH x ENTRY_W synchronous FIFO, first-word-fall-through from a register array.
// Flush has priority over push/pop; a push while full succeeds only alongside a pop.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [ENTRY_W-1:0]       wdata_i,
    output logic [ENTRY_W-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      rd_ptr_q;
    logic [AW-1:0]      wr_ptr_q;
    logic [CW-1:0]      count_q;
    logic [CW-1:0]      count_d;
    logic               do_push;
    logic               do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_C);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (flush_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                // When full, wr_ptr equals rd_ptr; the head is read out this
                // cycle before the overwrite lands at the edge.
                if (do_push) begin
                    mem_q[wr_ptr_q] <= wdata_i;
                    wr_ptr_q        <= wr_ptr_q + AW'(1);
                end
                if (do_pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive sequencer: drains bytes from the UART receiver into a tagged FIFO for the host.
// Define UART_RX_CTRL_STATS_EN to add saturating ferr/ovr/drop counters.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNTW  = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   rx_dataready,
    input  logic [7:0]             rx_data,
    input  logic                   rx_framing,
    input  logic                   rx_overrun,
    output logic                   rx_readdata,
    output logic                   rx_clearerr,
    output logic                   host_valid,
    output logic [7:0]             host_data,
    output logic                   host_ferr,
    input  logic                   host_ready,
    input  logic                   flush,
    input  logic                   clear_status,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   ovr_seen,
    output logic                   fifo_ovf,
`ifdef UART_RX_CTRL_STATS_EN
    output logic [CNTW-1:0]        ferr_cnt,
    output logic [CNTW-1:0]        ovr_cnt,
    output logic [CNTW-1:0]        drop_cnt,
`endif
    output logic [1:0]             dbg_state
);

    rx_state_e          state_q;
    logic               err_q;
    logic               rx_readdata_q;
    logic               rx_clearerr_q;
    logic               ovr_seen_q;
    logic               fifo_ovf_q;
    logic               capture;
    logic               host_pop;
    logic               drop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_rdata;

    // A byte is captured and pushed in the same IDLE cycle it is seen.
    assign capture  = (state_q == ST_IDLE) && rx_dataready;
    assign host_pop = host_valid && host_ready;
    assign drop     = capture && fifo_full && !host_pop && !flush;

    uart_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (capture),
        .pop_i   (host_pop),
        .flush_i (flush),
        .wdata_i ({rx_framing, rx_data}),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign host_valid  = !fifo_empty;
    assign host_data   = fifo_rdata[DATA_W-1:0];
    assign host_ferr   = fifo_rdata[ERR_BIT];
    assign rx_readdata = rx_readdata_q;
    assign rx_clearerr = rx_clearerr_q;
    assign ovr_seen    = ovr_seen_q;
    assign fifo_ovf    = fifo_ovf_q;
    assign dbg_state   = state_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            err_q         <= 1'b0;
            rx_readdata_q <= 1'b0;
            rx_clearerr_q <= 1'b0;
        end else begin
            rx_readdata_q <= 1'b0;
            rx_clearerr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_dataready) begin
                        err_q         <= rx_framing || rx_overrun;
                        rx_readdata_q <= 1'b1;
                        state_q       <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    rx_clearerr_q <= err_q;
                    state_q       <= err_q ? ST_CLEAR : ST_DRAIN;
                end
                ST_CLEAR: state_q <= ST_DRAIN;
                ST_DRAIN: state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    // Sticky status: a new event wins over a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovr_seen_q <= 1'b0;
            fifo_ovf_q <= 1'b0;
        end else begin
            if (capture && rx_overrun) begin
                ovr_seen_q <= 1'b1;
            end else if (clear_status) begin
                ovr_seen_q <= 1'b0;
            end
            if (drop) begin
                fifo_ovf_q <= 1'b1;
            end else if (clear_status) begin
                fifo_ovf_q <= 1'b0;
            end
        end
    end

`ifdef UART_RX_CTRL_STATS_EN
    localparam logic [CNTW-1:0] CNT_MAX = '1;
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    logic [CNTW-1:0] ferr_cnt_q;
    logic [CNTW-1:0] ovr_cnt_q;
    logic [CNTW-1:0] drop_cnt_q;

    function automatic logic [CNTW-1:0] bump(input logic [CNTW-1:0] c,
                                             input logic inc, input logic clr);
        logic [CNTW-1:0] r;
        r = clr ? '0 : c;
        if (inc && r != CNT_MAX) begin
            r = r + CNT_ONE;
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ferr_cnt_q <= '0;
            ovr_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            ferr_cnt_q <= bump(ferr_cnt_q, capture && rx_framing, clear_status);
            ovr_cnt_q  <= bump(ovr_cnt_q, capture && rx_overrun, clear_status);
            drop_cnt_q <= bump(drop_cnt_q, drop, clear_status);
        end
    end

    assign ferr_cnt = ferr_cnt_q;
    assign ovr_cnt  = ovr_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: a receiver driver feeds bytes, a host task pops and compares.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 8;
    localparam int CNTW  = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_dataready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_framing = 1'b0;
    logic       rx_overrun = 1'b0;
    logic       rx_readdata;
    logic       rx_clearerr;
    logic       host_valid;
    logic [7:0] host_data;
    logic       host_ferr;
    logic       host_ready = 1'b0;
    logic       flush = 1'b0;
    logic       clear_status = 1'b0;
    logic [$clog2(DEPTH):0] fifo_count;
    logic       ovr_seen;
    logic       fifo_ovf;
    logic [1:0] dbg_state;
`ifdef UART_RX_CTRL_STATS_EN
    logic [CNTW-1:0] ferr_cnt;
    logic [CNTW-1:0] ovr_cnt;
    logic [CNTW-1:0] drop_cnt;
`endif

    uart_rx_ctrl #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_dataready (rx_dataready),
        .rx_data      (rx_data),
        .rx_framing   (rx_framing),
        .rx_overrun   (rx_overrun),
        .rx_readdata  (rx_readdata),
        .rx_clearerr  (rx_clearerr),
        .host_valid   (host_valid),
        .host_data    (host_data),
        .host_ferr    (host_ferr),
        .host_ready   (host_ready),
        .flush        (flush),
        .clear_status (clear_status),
        .fifo_count   (fifo_count),
        .ovr_seen     (ovr_seen),
        .fifo_ovf     (fifo_ovf),
`ifdef UART_RX_CTRL_STATS_EN
        .ferr_cnt     (ferr_cnt),
        .ovr_cnt      (ovr_cnt),
        .drop_cnt     (drop_cnt),
`endif
        .dbg_state    (dbg_state)
    );

    // Clock and pulse counters
    always #5 clk = ~clk;

    int rd_cnt  = 0;
    int clr_cnt = 0;
    always @(posedge clk) begin
        if (rx_readdata) rd_cnt++;
        if (rx_clearerr) clr_cnt++;
    end

    // Scoreboard state
    logic [8:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Receiver driver: holds dataready until acknowledged, then lets the FSM settle.
    task automatic send_byte(input logic [7:0] d, input logic f, input logic o, input logic accept);
        bit seen;
        seen = 0;
        rx_data = d;
        rx_framing = f;
        rx_overrun = o;
        rx_dataready = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (rx_readdata) seen = 1;
        end
        if (!seen) check("rd_timeout", 32'd0, 32'd1);
        rx_dataready = 1'b0;
        rx_framing = 1'b0;
        rx_overrun = 1'b0;
        if (accept) exp_q.push_back({f, d});
        tick(4);
    endtask

    // Host side: compare the head entry against the scoreboard, then pop it.
    task automatic pop_check(input string tag);
        logic [8:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_empty_q"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, 32'(host_valid), 32'd1);
            check(tag, {23'd0, host_ferr, host_data}, {23'd0, e});
            host_ready = 1'b1;
            tick(1);
            host_ready = 1'b0;
        end
    endtask

    task automatic pulse_clear();
        clear_status = 1'b1;
        tick(1);
        clear_status = 1'b0;
    endtask

    initial begin
        int rd0;
        int clr0;
        logic [7:0] d;
        logic f;

        // Reset
        #12;
        check("rst_readdata", 32'(rx_readdata), 32'd0);
        check("rst_clearerr", 32'(rx_clearerr), 32'd0);
        check("rst_valid", 32'(host_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_status", {30'd0, ovr_seen, fifo_ovf}, 32'd0);
        check("rst_data", {23'd0, host_ferr, host_data}, 32'd0);
        reset_n = 1'b1;
        tick(2);

        // 1: plain byte
        rd0 = rd_cnt; clr0 = clr_cnt;
        send_byte(8'hA5, 1'b0, 1'b0, 1'b1);
        check("t1_rd_pulses", 32'(rd_cnt - rd0), 32'd1);
        check("t1_no_clear", 32'(clr_cnt - clr0), 32'd0);
        check("t1_count", 32'(fifo_count), 32'd1);
        pop_check("t1_head");
        check("t1_count_after", 32'(fifo_count), 32'd0);

        // 2: framing error, clearerr exactly two cycles after capture
        clr0 = clr_cnt;
        rx_data = 8'h3C; rx_framing = 1'b1; rx_dataready = 1'b1;
        tick(1);
        check("t2_readdata_n1", 32'(rx_readdata), 32'd1);
        check("t2_valid_n1", 32'(host_valid), 32'd1);
        rx_dataready = 1'b0; rx_framing = 1'b0;
        exp_q.push_back({1'b1, 8'h3C});
        check("t2_clear_n1", 32'(rx_clearerr), 32'd0);
        tick(1);
        check("t2_readdata_n2", 32'(rx_readdata), 32'd0);
        check("t2_clear_n2", 32'(rx_clearerr), 32'd1);
        tick(1);
        check("t2_clear_n3", 32'(rx_clearerr), 32'd0);
        tick(2);
        check("t2_clear_pulses", 32'(clr_cnt - clr0), 32'd1);
        check("t2_ovr_seen", 32'(ovr_seen), 32'd0);
        pop_check("t2_head");

        // 3: nine bytes into an eight-deep FIFO
        rd0 = rd_cnt;
        for (int i = 0; i < 9; i++) begin
            send_byte(8'h40 + 8'(i), 1'(i % 3 == 0), 1'b0, i < DEPTH);
        end
        check("t3_count", 32'(fifo_count), 32'(DEPTH));
        check("t3_ovf", 32'(fifo_ovf), 32'd1);
        check("t3_rd_pulses", 32'(rd_cnt - rd0), 32'd9);
        pulse_clear();
        check("t3_ovf_cleared", 32'(fifo_ovf), 32'd0);

        // 4: full FIFO, pop coincides with capture
        check({"t4_head"}, {23'd0, host_ferr, host_data}, {23'd0, exp_q.pop_front()});
        host_ready = 1'b1;
        rx_data = 8'h77; rx_dataready = 1'b1;
        exp_q.push_back({1'b0, 8'h77});
        tick(1);
        host_ready = 1'b0;
        check("t4_readdata", 32'(rx_readdata), 32'd1);
        rx_dataready = 1'b0;
        tick(4);
        check("t4_count", 32'(fifo_count), 32'(DEPTH));
        check("t4_ovf", 32'(fifo_ovf), 32'd0);
        while (exp_q.size() > 0) pop_check("t4_drain");
        check("t4_empty", 32'(fifo_count), 32'd0);

        // 5: overrun byte and status clear
        clr0 = clr_cnt;
        send_byte(8'h11, 1'b0, 1'b1, 1'b1);
        check("t5_ovr_seen", 32'(ovr_seen), 32'd1);
        check("t5_clear_pulse", 32'(clr_cnt - clr0), 32'd1);
`ifdef UART_RX_CTRL_STATS_EN
        check("t5_ovr_cnt", 32'(ovr_cnt), 32'd1);
`endif
        pulse_clear();
        check("t5_ovr_cleared", 32'(ovr_seen), 32'd0);
`ifdef UART_RX_CTRL_STATS_EN
        check("t5_ovr_cnt_clr", 32'(ovr_cnt), 32'd0);
`endif
        pop_check("t5_head");

        // Random bytes through the scoreboard
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom_range(0, 255));
            f = 1'($urandom_range(0, 1));
            send_byte(d, f, 1'b0, 1'b1);
        end
        check("rand_count", 32'(fifo_count), 32'd6);
        while (exp_q.size() > 0) pop_check("rand_head");

        // Flush empties the FIFO in one cycle
        send_byte(8'hC1, 1'b0, 1'b0, 1'b1);
        send_byte(8'hC2, 1'b0, 1'b0, 1'b1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        exp_q.delete();
        check("flush_count", 32'(fifo_count), 32'd0);
        check("flush_valid", 32'(host_valid), 32'd0);

        // 6: reset during ACK
        rx_data = 8'h5A; rx_overrun = 1'b1; rx_dataready = 1'b1;
        tick(1);
        check("t6_in_ack", 32'(rx_readdata), 32'd1);
        check("t6_ovr_before", 32'(ovr_seen), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_readdata", 32'(rx_readdata), 32'd0);
        check("t6_count", 32'(fifo_count), 32'd0);
        check("t6_status", {30'd0, ovr_seen, fifo_ovf}, 32'd0);
        rx_dataready = 1'b0; rx_overrun = 1'b0;
        #3;
        reset_n = 1'b1;
        tick(2);
        send_byte(8'h99, 1'b0, 1'b0, 1'b1);
        pop_check("t6_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
